// File: rtl/clk_edge_monitor.sv
// Synchronizes a slow clock/strobe into clk, emits rise/fall enables, measures period and lock/loss.
// Optional high-phase measurement enabled by defining DUTY_MEAS_EN.
module clk_edge_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOL         = 1,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] high_time
);

  localparam int unsigned     MCNT_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOL_W      = CNT_W'(TOL);

  typedef enum logic [1:0] {IDLE, MEAS, LOCKING, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   e_rise;
  logic                   e_fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       meas;
  logic [CNT_W-1:0]       diff;
  logic                   in_tol;
  logic                   timeout;

  state_t                 state;
  state_t                 state_next;
  logic [MCNT_W-1:0]      mcnt;
  logic [MCNT_W-1:0]      mcnt_next;
  logic [MCNT_W-1:0]      mcnt_inc;
  logic [CNT_W-1:0]       period_next;
  logic                   period_valid_next;
  logic                   lost_next;

  assign s       = sync[SYNC_STAGES-1];
  assign e_rise  = s & ~s_d;
  assign e_fall  = ~s & s_d;
  assign meas    = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  assign diff    = (meas >= period) ? meas - period : period - meas;
  assign in_tol  = (diff <= TOL_W);
  assign timeout = (state != IDLE) && (cnt == TIMEOUT_M1) && !e_rise;
  assign mcnt_inc = mcnt + MCNT_W'(1);

  // Synchronizer chain and registered edge enables
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      s_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_in};
      s_d  <= s;
      rise <= e_rise;
      fall <= e_fall;
    end
  end

  // Rise-to-rise counter, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (e_rise) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      lost         <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_next;
      mcnt         <= mcnt_next;
      period       <= period_next;
      period_valid <= period_valid_next;
      lost         <= lost_next;
      locked       <= (state_next == LOCKED);
    end
  end

  // Acquisition / lock tracking; a rise always beats a coincident timeout
  always_comb begin
    state_next        = state;
    mcnt_next         = mcnt;
    period_next       = period;
    period_valid_next = 1'b0;
    lost_next         = 1'b0;
    if (e_rise) begin
      case (state)
        IDLE: state_next = MEAS;
        MEAS: begin
          period_next       = meas;
          period_valid_next = 1'b1;
          mcnt_next         = '0;
          state_next        = LOCKING;
        end
        LOCKING: begin
          period_next       = meas;
          period_valid_next = 1'b1;
          if (in_tol) begin
            mcnt_next = mcnt_inc;
            if (mcnt_inc >= MCNT_W'(LOCK_COUNT)) begin
              state_next = LOCKED;
            end
          end else begin
            mcnt_next = '0;
          end
        end
        LOCKED: begin
          period_next       = meas;
          period_valid_next = 1'b1;
          if (!in_tol) begin
            mcnt_next  = '0;
            state_next = LOCKING;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      lost_next  = 1'b1;
      mcnt_next  = '0;
      state_next = IDLE;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt;
  logic             hvalid;

  // High-phase counter; only reports once a rise has been seen since acquisition began
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt      <= '0;
      hvalid    <= 1'b0;
      high_time <= '0;
    end else begin
      if (e_rise) begin
        hcnt <= CNT_W'(1);
      end else if (s && hcnt != CNT_MAX) begin
        hcnt <= hcnt + CNT_W'(1);
      end
      if (e_rise) begin
        hvalid <= 1'b1;
      end else if (lost_next) begin
        hvalid <= 1'b0;
      end
      if (e_fall && hvalid) begin
        high_time <= hcnt;
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule
